fetch_pc: RTL and testbench

Program-counter and next-PC stage of the single-cycle MIPS datapath. Sits directly upstream of the instruction memory: holds the architectural PC and updates it each clock with the sequential, branch, jump or register target. Drives the word-aligned, base-relative fetch address the instruction memory indexes with bits [11:2]. Guards the fetch window: an out-of-window or misaligned target raises a sticky fault and freezes fetch.

---
 rtl/fetch_pc_pkg.sv | 16 +
 rtl/fetch_pc_npc_calc.sv | 42 ++++
 rtl/fetch_pc.sv | 70 +++++++
 tb/tb_fetch_pc.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared constants and next-PC source encodings for the fetch stage,
// instruction memory address translation and verification.
package fetch_pc_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

endpackage : fetch_pc_pkg

// File: rtl/fetch_pc_npc_calc.sv
// Combinational next-PC target mux and fetch-window legality check.
module npc_calc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_target,
  output logic [31:0] target_c,
  output logic        legal_c
);

  localparam logic [31:0] WIN_END = RESET_PC + 32'(4 * IM_WORDS);

  logic [31:0] seq_c;
  logic [31:0] br_off_c;

  assign seq_c    = pc + 32'd4;
  assign br_off_c = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target_c = seq_c;
    unique case (npc_sel_e'(npc_sel))
      NPC_SEQ: target_c = seq_c;
      NPC_BR:  target_c = branch_taken ? (seq_c + br_off_c) : seq_c;
      NPC_J:   target_c = {seq_c[31:28], imm26, 2'b00};
      NPC_JR:  target_c = jr_target;
      default: target_c = seq_c;
    endcase
  end

  // Wrapped or out-of-window targets both fail the unsigned window compare.
  assign legal_c = (target_c[1:0] == 2'b00) &&
                   (target_c >= RESET_PC) &&
                   (target_c < WIN_END);

endmodule : npc_calc

// File: rtl/fetch_pc.sv
// Architectural PC register with sticky fetch-window fault; drives the
// base-relative instruction memory address.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] im_addr,
  output logic        fetch_fault
);

  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [31:0] target_c;
  logic        legal_c;

  npc_calc #(
    .RESET_PC (RESET_PC),
    .IM_WORDS (IM_WORDS)
  ) u_npc_calc (
    .pc           (pc_q),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .imm26        (imm26),
    .jr_target    (jr_target),
    .target_c     (target_c),
    .legal_c      (legal_c)
  );

  // A frozen or stalled PC never judges the target.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (!fault_q && !stall) begin
      if (legal_c) begin
        pc_d = target_c;
      end else begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign im_addr     = pc_q - RESET_PC;
  assign fetch_fault = fault_q;

endmodule : fetch_pc

// File: tb/tb_fetch_pc.sv
// Directed vector bench for fetch_pc: per-cycle stimulus with expected PC/fault.
module tb_fetch_pc;
  import fetch_pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] im_addr;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  sel;
    logic        bt;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] jr;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  fetch_pc dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .imm26        (imm26),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .im_addr      (im_addr),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic stl, input logic [1:0] sel,
                              input logic bt, input logic [15:0] i16, input logic [25:0] i26,
                              input logic [31:0] jr, input logic [31:0] exp_pc,
                              input logic exp_fault);
    vec_t v;
    v.rst = rst; v.stl = stl; v.sel = sel; v.bt = bt; v.i16 = i16; v.i26 = i26;
    v.jr = jr; v.exp_pc = exp_pc; v.exp_fault = exp_fault;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] exp_pc, input logic exp_fault);
    check32({tag, " pc"}, pc, exp_pc);
    check32({tag, " pc_plus4"}, pc_plus4, exp_pc + 32'd4);
    check32({tag, " im_addr"}, im_addr, exp_pc - 32'h0000_3000);
    check32({tag, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, exp_fault});
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; npc_sel = v.sel; branch_taken = v.bt;
    imm16 = v.i16; imm26 = v.i26; jr_target = v.jr;
  endtask

  task automatic step_check(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    check_state(tag, v.exp_pc, v.exp_fault);
  endtask

  initial begin
    drive(mk(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h0, 0));

    // reset + free-running sequential fetch
    vecs.push_back(mk(1, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 0));
    vecs.push_back(mk(0, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3004, 0));
    vecs.push_back(mk(0, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3008, 0));
    vecs.push_back(mk(0, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_300C, 0));
    vecs.push_back(mk(0, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3010, 0));
    // branch taken backwards / not taken
    vecs.push_back(mk(0, 0, NPC_BR,  1, 16'hFFFE, 26'h0, 32'h0, 32'h0000_300C, 0));
    vecs.push_back(mk(0, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3010, 0));
    vecs.push_back(mk(0, 0, NPC_BR,  0, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3014, 0));
    // jump and jr
    vecs.push_back(mk(0, 0, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_3020, 32'h0000_3020, 0));
    vecs.push_back(mk(0, 0, NPC_J,   0, 16'h0000, 26'h0000C10, 32'h0, 32'h0000_3040, 0));
    vecs.push_back(mk(0, 0, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_3100, 32'h0000_3100, 0));
    // stall two cycles at 0x3008 with jump pending, then release
    vecs.push_back(mk(0, 0, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_3008, 32'h0000_3008, 0));
    vecs.push_back(mk(0, 1, NPC_J,   0, 16'h0000, 26'h0000C10, 32'h0, 32'h0000_3008, 0));
    vecs.push_back(mk(0, 1, NPC_J,   0, 16'h0000, 26'h0000C10, 32'h0, 32'h0000_3008, 0));
    vecs.push_back(mk(0, 0, NPC_J,   0, 16'h0000, 26'h0000C10, 32'h0, 32'h0000_3040, 0));
    // stall masks an illegal target; misaligned jr faults; later legal targets ignored
    vecs.push_back(mk(0, 1, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_3102, 32'h0000_3040, 0));
    vecs.push_back(mk(0, 0, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_3102, 32'h0000_3040, 1));
    vecs.push_back(mk(0, 0, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_3100, 32'h0000_3040, 1));
    vecs.push_back(mk(0, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3040, 1));
    // reset with fault and stall both set
    vecs.push_back(mk(1, 1, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 0));
    // jr past window end
    vecs.push_back(mk(0, 0, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_4000, 32'h0000_3000, 1));
    vecs.push_back(mk(1, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 0));
    // last window word, then seq runs off the end
    vecs.push_back(mk(0, 0, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_3FFC, 32'h0000_3FFC, 0));
    vecs.push_back(mk(0, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3FFC, 1));
    vecs.push_back(mk(1, 1, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 0));
    // below window base
    vecs.push_back(mk(0, 0, NPC_JR,  0, 16'h0000, 26'h0, 32'h0000_2FFC, 32'h0000_3000, 1));
    vecs.push_back(mk(1, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 0));
    // large forward branch leaves window: 0x3004 + 0x1FFFC = 0x23000
    vecs.push_back(mk(0, 0, NPC_BR,  1, 16'h7FFF, 26'h0, 32'h0, 32'h0000_3000, 1));
    vecs.push_back(mk(1, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 0));
    // jump into the upper region keeps pc_plus4[31:28]=0 -> 0x0FFFFFFC illegal
    vecs.push_back(mk(0, 0, NPC_J,   0, 16'h0000, 26'h3FFFFFF, 32'h0, 32'h0000_3000, 1));
    vecs.push_back(mk(1, 0, NPC_SEQ, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_3000, 0));
    // branch lands on last window word; not-taken branch then exits window
    vecs.push_back(mk(0, 0, NPC_BR,  1, 16'h03FE, 26'h0, 32'h0, 32'h0000_3FFC, 0));
    vecs.push_back(mk(0, 0, NPC_BR,  0, 16'hFFFE, 26'h0, 32'h0, 32'h0000_3FFC, 1));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step_check(vecs[i], $sformatf("vec%0d", i));
    end

    // Fault freeze holds across a run of varied legal targets and stalls.
    step_check(mk(0, 0, NPC_JR, 0, 16'h0, 26'h0, 32'h0000_3200, 32'h0000_3FFC, 1), "frz0");
    for (int k = 0; k < 4; k++) begin
      step_check(mk(0, k[0], NPC_J, 0, 16'h0, 26'h0000C00 + 26'(k), 32'h0,
                    32'h0000_3FFC, 1), $sformatf("frz%0d", k + 1));
    end

    // Reset then long stall: pc pinned at base even with illegal targets queued.
    step_check(mk(1, 0, NPC_SEQ, 0, 16'h0, 26'h0, 32'h0, 32'h0000_3000, 0), "rst_b");
    for (int k = 0; k < 3; k++) begin
      step_check(mk(0, 1, NPC_JR, 0, 16'h0, 26'h0, 32'h0000_0001, 32'h0000_3000, 0),
                 $sformatf("stl%0d", k));
    end
    step_check(mk(0, 0, NPC_SEQ, 0, 16'h0, 26'h0, 32'h0, 32'h0000_3004, 0), "stl_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_pc
